// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: sequencer for a tic-tac-toe game against a combinational AI.
// Holds the registered X and O boards and accepts X moves through a valid/ready
// handshake. Drives the boards to the AI, samples its one-hot O move, and
// reports win, draw and illegal moves.
// Optional feature macro: TTT_AI_CHECK_EN. When it is defined, the AI's move is
// validated before it is applied. When it is undefined, the move is applied
// unchecked and ai_err is tied low.
module ttt_game_ctrl #(
  parameter int AI_WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       x_move_valid,
  input  logic [8:0] x_move,
  output logic       x_move_ready,
  input  logic [8:0] ai_move,
  output logic [8:0] xin_out,
  output logic [8:0] oin_out,
  output logic       illegal_move,
  output logic       ai_err,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_WAIT_X  = 3'd0,
    S_CHECK_X = 3'd1,
    S_AI_WAIT = 3'd2,
    S_CHECK_O = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // The wait counter is 4 bits wide. A parameter outside 1..15 is clamped so
  // the counter can never start at zero or wrap.
  localparam logic [3:0] WAIT_LOAD = (AI_WAIT_CYCLES < 1)  ? 4'd1 :
                                     (AI_WAIT_CYCLES > 15) ? 4'd15 :
                                     4'(AI_WAIT_CYCLES);

  state_t     r_state;
  state_t     w_stateNext;
  logic [8:0] r_xBoard;
  logic [8:0] w_xNext;
  logic [8:0] r_oBoard;
  logic [8:0] w_oNext;
  logic [1:0] r_winner;
  logic [1:0] w_winnerNext;
  logic       r_gameOver;
  logic       w_gameOverNext;
  logic       r_illegal;
  logic       w_illegalNext;
  logic [3:0] r_waitCnt;
  logic [3:0] w_cntNext;
  logic [8:0] w_occupied;
`ifdef TTT_AI_CHECK_EN
  logic       r_aiErr;
  logic       w_aiErrNext;
  logic       w_aiValid;
`endif

  // A legal move selects exactly one cell.
  function automatic logic f_isOneHot(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

  // True when the board holds any of the three rows, three columns or two diagonals.
  function automatic logic f_hasLine(input logic [8:0] b);
    return (&b[8:6]) | (&b[5:3]) | (&b[2:0]) |
           (b[8] & b[5] & b[2]) | (b[7] & b[4] & b[1]) | (b[6] & b[3] & b[0]) |
           (b[8] & b[4] & b[0]) | (b[6] & b[4] & b[2]);
  endfunction

  assign w_occupied = r_xBoard | r_oBoard;

`ifdef TTT_AI_CHECK_EN
  assign w_aiValid = f_isOneHot(ai_move) && ((ai_move & w_occupied) == 9'd0);
`endif

  // Next-state and next-register logic. new_game overrides everything else.
  always_comb begin
    w_stateNext    = r_state;
    w_xNext        = r_xBoard;
    w_oNext        = r_oBoard;
    w_winnerNext   = r_winner;
    w_gameOverNext = r_gameOver;
    w_illegalNext  = 1'b0;
    w_cntNext      = r_waitCnt;
`ifdef TTT_AI_CHECK_EN
    w_aiErrNext    = r_aiErr;
`endif
    if (new_game) begin
      w_stateNext    = S_WAIT_X;
      w_xNext        = 9'd0;
      w_oNext        = 9'd0;
      w_winnerNext   = WIN_NONE;
      w_gameOverNext = 1'b0;
      w_cntNext      = 4'd0;
`ifdef TTT_AI_CHECK_EN
      w_aiErrNext    = 1'b0;
`endif
    end else begin
      case (r_state)
        S_WAIT_X: begin
          if (x_move_valid) begin
            if (f_isOneHot(x_move) && ((x_move & w_occupied) == 9'd0)) begin
              w_xNext     = r_xBoard | x_move;
              w_stateNext = S_CHECK_X;
            end else begin
              w_illegalNext = 1'b1;
            end
          end
        end
        S_CHECK_X: begin
          if (f_hasLine(r_xBoard)) begin
            w_winnerNext   = WIN_X;
            w_gameOverNext = 1'b1;
            w_stateNext    = S_DONE;
          end else if (w_occupied == 9'h1FF) begin
            w_winnerNext   = WIN_DRAW;
            w_gameOverNext = 1'b1;
            w_stateNext    = S_DONE;
          end else begin
            w_cntNext   = WAIT_LOAD;
            w_stateNext = S_AI_WAIT;
          end
        end
        S_AI_WAIT: begin
          if (r_waitCnt <= 4'd1) begin
`ifdef TTT_AI_CHECK_EN
            if (w_aiValid) begin
              w_oNext     = r_oBoard | ai_move;
              w_stateNext = S_CHECK_O;
            end else begin
              w_aiErrNext    = 1'b1;
              w_winnerNext   = WIN_NONE;
              w_gameOverNext = 1'b1;
              w_stateNext    = S_DONE;
            end
`else
            w_oNext     = r_oBoard | ai_move;
            w_stateNext = S_CHECK_O;
`endif
          end else begin
            w_cntNext = r_waitCnt - 4'd1;
          end
        end
        S_CHECK_O: begin
          if (f_hasLine(r_oBoard)) begin
            w_winnerNext   = WIN_O;
            w_gameOverNext = 1'b1;
            w_stateNext    = S_DONE;
          end else if (w_occupied == 9'h1FF) begin
            w_winnerNext   = WIN_DRAW;
            w_gameOverNext = 1'b1;
            w_stateNext    = S_DONE;
          end else begin
            w_stateNext = S_WAIT_X;
          end
        end
        S_DONE: begin
          w_stateNext = S_DONE;
        end
        default: begin
          w_stateNext = S_WAIT_X;
        end
      endcase
    end
  end

  // State and board registers. Reset behaves exactly like new_game.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_WAIT_X;
      r_xBoard   <= 9'd0;
      r_oBoard   <= 9'd0;
      r_winner   <= WIN_NONE;
      r_gameOver <= 1'b0;
      r_illegal  <= 1'b0;
      r_waitCnt  <= 4'd0;
    end else begin
      r_state    <= w_stateNext;
      r_xBoard   <= w_xNext;
      r_oBoard   <= w_oNext;
      r_winner   <= w_winnerNext;
      r_gameOver <= w_gameOverNext;
      r_illegal  <= w_illegalNext;
      r_waitCnt  <= w_cntNext;
    end
  end

`ifdef TTT_AI_CHECK_EN
  // Sticky AI fault flag. Only new_game or reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aiErr <= 1'b0;
    end else begin
      r_aiErr <= w_aiErrNext;
    end
  end

  assign ai_err = r_aiErr;
`else
  assign ai_err = 1'b0;
`endif

  assign x_move_ready = (r_state == S_WAIT_X);
  assign xin_out      = r_xBoard;
  assign oin_out      = r_oBoard;
  assign illegal_move = r_illegal;
  assign game_over    = r_gameOver;
  assign winner       = r_winner;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: self-checking bench for ttt_game_ctrl.
// It uses two instances: dutA with a one-cycle AI wait and dutB with a four-cycle AI wait.
// A simple bench AI plays the centre if it is free, otherwise the lowest free cell.
module tb_ttt_game_ctrl;

  localparam int WAIT_A = 1;
  localparam int WAIT_B = 4;

  logic clk = 1'b0;
  logic rst;

  logic       newGameA, xValidA, readyA, illegalA, aiErrA, overA, aiForceA;
  logic [8:0] xMoveA, aiMoveA, xinA, oinA, aiForceValA;
  logic [1:0] winnerA;

  logic       newGameB, xValidB, readyB, illegalB, aiErrB, overB;
  logic [8:0] xMoveB, aiMoveB, xinB, oinB;
  logic [1:0] winnerB;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [8:0] xMove;
    logic       expIllegal;
    int         expCycles;
    logic [8:0] expX;
    logic [8:0] expO;
    logic [1:0] expWinner;
    logic       expOver;
  } moveVec_t;

  moveVec_t moveTable [7];

  // Reference model: cell owners 0 = empty, 1 = X, 2 = O
  int         owner [9];
  logic [1:0] mWinner;
  logic       mOver;
  int lineCells [8][3] = '{'{8,7,6}, '{5,4,3}, '{2,1,0}, '{8,5,2},
                           '{7,4,1}, '{6,3,0}, '{8,4,0}, '{6,4,2}};

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [8:0] benchAi(input logic [8:0] x, input logic [8:0] o);
    logic [8:0] occ;
    occ = x | o;
    if (!occ[4]) return 9'b000010000;
    for (int i = 0; i < 9; i++)
      if (!occ[i]) return 9'b1 << i;
    return 9'd0;
  endfunction

  // Bench AI drives the DUTs' ai_move from their current boards
  always_comb aiMoveA = aiForceA ? aiForceValA : benchAi(xinA, oinA);
  always_comb aiMoveB = benchAi(xinB, oinB);

  ttt_game_ctrl #(.AI_WAIT_CYCLES(WAIT_A)) dutA (
    .clk(clk), .reset(rst), .new_game(newGameA), .x_move_valid(xValidA),
    .x_move(xMoveA), .x_move_ready(readyA), .ai_move(aiMoveA),
    .xin_out(xinA), .oin_out(oinA), .illegal_move(illegalA),
    .ai_err(aiErrA), .game_over(overA), .winner(winnerA)
  );

  ttt_game_ctrl #(.AI_WAIT_CYCLES(WAIT_B)) dutB (
    .clk(clk), .reset(rst), .new_game(newGameB), .x_move_valid(xValidB),
    .x_move(xMoveB), .x_move_ready(readyB), .ai_move(aiMoveB),
    .xin_out(xinB), .oin_out(oinB), .illegal_move(illegalB),
    .ai_err(aiErrB), .game_over(overB), .winner(winnerB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [8:0] modelVec(input int who);
    logic [8:0] v;
    v = '0;
    for (int i = 0; i < 9; i++)
      if (owner[i] == who) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic modelLine(input int who);
    for (int l = 0; l < 8; l++)
      if (owner[lineCells[l][0]] == who && owner[lineCells[l][1]] == who &&
          owner[lineCells[l][2]] == who) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic modelFull();
    for (int i = 0; i < 9; i++)
      if (owner[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 9; i++) owner[i] = 0;
    mWinner = 2'b00;
    mOver = 1'b0;
  endtask

  // Play one full X move plus AI reply on the model. Report whether the move
  // is rejected and how many cycles pass until the DUT is ready again or the game is over.
  task automatic modelMove(input logic [8:0] m, output logic expIll, output int expCyc);
    int idx;
    logic [8:0] ai;
    idx = -1;
    expIll = 1'b0;
    expCyc = 1;
    if (mOver) return;
    if ($countones(m) == 1)
      for (int i = 0; i < 9; i++) if (m[i]) idx = i;
    if (idx < 0 || owner[idx] != 0) begin
      expIll = 1'b1;
      return;
    end
    owner[idx] = 1;
    expCyc = 2;
    if (modelLine(1)) begin mWinner = 2'b01; mOver = 1'b1; return; end
    if (modelFull()) begin mWinner = 2'b11; mOver = 1'b1; return; end
    expCyc = 3 + WAIT_A;
    ai = benchAi(modelVec(1), modelVec(2));
    for (int i = 0; i < 9; i++) if (ai[i]) owner[i] = 2;
    if (modelLine(2)) begin mWinner = 2'b10; mOver = 1'b1; end
    else if (modelFull()) begin mWinner = 2'b11; mOver = 1'b1; end
  endtask

  task automatic pulseNewGameA();
    newGameA = 1'b1;
    tick();
    newGameA = 1'b0;
  endtask

  // Offer one X move to dutA for a single cycle. Wait (bounded) for ready or game_over.
  task automatic applyStimulus(input logic [8:0] m, output logic obsIllegal, output int obsCycles);
    xMoveA = m;
    xValidA = 1'b1;
    tick();
    xValidA = 1'b0;
    xMoveA = '0;
    obsIllegal = illegalA;
    obsCycles = 1;
    while (!readyA && !overA && obsCycles < 40) begin
      tick();
      obsCycles++;
    end
  endtask

  task automatic runMoveA(input string name, input logic [8:0] m, input logic eIll, input int eCyc,
                          input logic [8:0] eX, input logic [8:0] eO, input logic [1:0] eW,
                          input logic eOver, input logic eAiErr);
    logic obsIll;
    int obsCyc;
    applyStimulus(m, obsIll, obsCyc);
    checkOutput({name, " illegal"}, 32'(obsIll), 32'(eIll));
    checkOutput({name, " cycles"}, obsCyc, eCyc);
    checkOutput({name, " xin"}, 32'(xinA), 32'(eX));
    checkOutput({name, " oin"}, 32'(oinA), 32'(eO));
    checkOutput({name, " winner"}, 32'(winnerA), 32'(eW));
    checkOutput({name, " game_over"}, 32'(overA), 32'(eOver));
    checkOutput({name, " ready"}, 32'(readyA), 32'(!eOver));
    checkOutput({name, " ai_err"}, 32'(aiErrA), 32'(eAiErr));
  endtask

  // Hard time limit so the bench always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic eIll;
    int eCyc;
    int cnt;
    logic [8:0] m;

    moveTable[0] = '{9'b000000001, 1'b0, 4, 9'b000000001, 9'b000010000, 2'b00, 1'b0};
    moveTable[1] = '{9'b000010000, 1'b1, 1, 9'b000000001, 9'b000010000, 2'b00, 1'b0};
    moveTable[2] = '{9'b000000011, 1'b1, 1, 9'b000000001, 9'b000010000, 2'b00, 1'b0};
    moveTable[3] = '{9'b100000000, 1'b0, 4, 9'b100000001, 9'b000010010, 2'b00, 1'b0};
    moveTable[4] = '{9'b010000000, 1'b0, 4, 9'b110000001, 9'b000010110, 2'b00, 1'b0};
    moveTable[5] = '{9'b001000000, 1'b0, 2, 9'b111000001, 9'b000010110, 2'b01, 1'b1};
    moveTable[6] = '{9'b000001000, 1'b0, 1, 9'b111000001, 9'b000010110, 2'b01, 1'b1};

    newGameA = 0; xValidA = 0; xMoveA = '0; aiForceA = 0; aiForceValA = '0;
    newGameB = 0; xValidB = 0; xMoveB = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset xin", 32'(xinA), 32'h0);
    checkOutput("reset oin", 32'(oinA), 32'h0);
    checkOutput("reset ready", 32'(readyA), 32'h1);
    checkOutput("reset winner", 32'(winnerA), 32'h0);
    checkOutput("reset game_over", 32'(overA), 32'h0);
    checkOutput("reset illegal", 32'(illegalA), 32'h0);
    checkOutput("reset ai_err", 32'(aiErrA), 32'h0);
    checkOutput("reset B ready", 32'(readyB), 32'h1);
    checkOutput("reset B boards", 32'({xinB, oinB}), 32'h0);

    // Table-driven game on dutA
    pulseNewGameA();
    for (int i = 0; i < 7; i++)
      runMoveA($sformatf("table%0d", i), moveTable[i].xMove, moveTable[i].expIllegal,
               moveTable[i].expCycles, moveTable[i].expX, moveTable[i].expO,
               moveTable[i].expWinner, moveTable[i].expOver, 1'b0);

    // new_game clears a finished game
    pulseNewGameA();
    checkOutput("newgame boards", 32'({xinA, oinA}), 32'h0);
    checkOutput("newgame over", 32'(overA), 32'h0);
    checkOutput("newgame winner", 32'(winnerA), 32'h0);
    checkOutput("newgame ready", 32'(readyA), 32'h1);

    // illegal_move lasts exactly one cycle
    runMoveA("pw setup", 9'b000000001, 1'b0, 4, 9'b000000001, 9'b000010000, 2'b00, 1'b0, 1'b0);
    xMoveA = 9'b000010000;
    xValidA = 1'b1;
    tick();
    xValidA = 1'b0;
    checkOutput("pulse high", 32'(illegalA), 32'h1);
    tick();
    checkOutput("pulse low", 32'(illegalA), 32'h0);
    checkOutput("pulse ready", 32'(readyA), 32'h1);

    // X wins on the left column
    pulseNewGameA();
    runMoveA("xw1", 9'b100000000, 1'b0, 4, 9'b100000000, 9'b000010000, 2'b00, 1'b0, 1'b0);
    runMoveA("xw2", 9'b000100000, 1'b0, 4, 9'b100100000, 9'b000010001, 2'b00, 1'b0, 1'b0);
    runMoveA("xw3", 9'b000000100, 1'b0, 2, 9'b100100100, 9'b000010001, 2'b01, 1'b1, 1'b0);
    runMoveA("xw ignored", 9'b000000010, 1'b0, 1, 9'b100100100, 9'b000010001, 2'b01, 1'b1, 1'b0);

    // AI forced onto an occupied cell
    pulseNewGameA();
    aiForceA = 1'b1;
    aiForceValA = 9'b000000001;
`ifdef TTT_AI_CHECK_EN
    runMoveA("aifault", 9'b000000001, 1'b0, 2 + WAIT_A, 9'b000000001, 9'b000000000, 2'b00, 1'b1, 1'b1);
`else
    runMoveA("aifault", 9'b000000001, 1'b0, 3 + WAIT_A, 9'b000000001, 9'b000000001, 2'b00, 1'b0, 1'b0);
`endif
    aiForceA = 1'b0;

    // dutB full move latency
    newGameB = 1'b1; tick(); newGameB = 1'b0;
    xMoveB = 9'b000000001; xValidB = 1'b1; tick(); xValidB = 1'b0;
    cnt = 1;
    while (!readyB && cnt < 40) begin tick(); cnt++; end
    checkOutput("B latency", cnt, 3 + WAIT_B);
    checkOutput("B boards", 32'({xinB, oinB}), 32'({9'b000000001, 9'b000010000}));

    // Abort during AI_WAIT with new_game
    newGameB = 1'b1; tick(); newGameB = 1'b0;
    xMoveB = 9'b000000001; xValidB = 1'b1; tick(); xValidB = 1'b0;
    tick();
    tick();
    checkOutput("abortN mid xin", 32'(xinB), 32'h1);
    checkOutput("abortN mid ready", 32'(readyB), 32'h0);
    newGameB = 1'b1; tick(); newGameB = 1'b0;
    checkOutput("abortN boards", 32'({xinB, oinB}), 32'h0);
    checkOutput("abortN ready", 32'(readyB), 32'h1);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("abortN later oin", 32'(oinB), 32'h0);
    checkOutput("abortN later ready", 32'(readyB), 32'h1);

    // Abort during AI_WAIT with reset
    xMoveB = 9'b000000010; xValidB = 1'b1; tick(); xValidB = 1'b0;
    tick();
    tick();
    checkOutput("abortR mid xin", 32'(xinB), 32'h2);
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("abortR boards", 32'({xinB, oinB}), 32'h0);
    checkOutput("abortR ready", 32'(readyB), 32'h1);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("abortR later oin", 32'(oinB), 32'h0);
    checkOutput("abortR over", 32'(overB), 32'h0);

    // Randomised games against the reference model
    for (int g = 0; g < 25; g++) begin
      pulseNewGameA();
      modelReset();
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 4) == 0) m = 9'($urandom);
        else m = 9'b1 << $urandom_range(0, 8);
        modelMove(m, eIll, eCyc);
        runMoveA($sformatf("rand g%0d k%0d", g, k), m, eIll, eCyc,
                 modelVec(1), modelVec(2), mWinner, mOver, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
